// File: rtl/adder8_1_err_monitor_if.sv
// Sample stream from the adder8_1 partition into the error monitor: window start,
// the approximate/exact result pair, and the valid/ready handshake.
interface adder8_1_err_monitor_if #(
    parameter int W = 4
);
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] approx;
    logic [W-1:0] exact;

    modport master (
        output start,
        output in_valid,
        output approx,
        output exact,
        input  in_ready
    );

    modport slave (
        input  start,
        input  in_valid,
        input  approx,
        input  exact,
        output in_ready
    );
endinterface

// File: rtl/adder8_1_err_monitor.sv
// Error-statistics monitor for the approximate adder8_1 partition: accumulates
// error count, max/summed absolute error and Hamming distance over NSAMP pairs.
module adder8_1_err_monitor #(
    parameter int W     = 4,
    parameter int NSAMP = 128,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder8_1_err_monitor_if.slave mon,
    output logic                 busy,
    output logic                 done,
    output logic [CNTW-1:0]      samp_cnt,
    output logic [CNTW-1:0]      err_cnt,
    output logic [W-1:0]         max_err,
    output logic [CNTW+W-1:0]    sum_abs_err,
    output logic [CNTW+2:0]      hd_sum
);

    localparam int              HDW  = $clog2(W + 1);
    localparam logic [CNTW-1:0] LAST = CNTW'(NSAMP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNTW-1:0]   samp_cnt_q, samp_cnt_d;
    logic [CNTW-1:0]   err_cnt_q, err_cnt_d;
    logic [W-1:0]      max_err_q, max_err_d;
    logic [CNTW+W-1:0] sum_abs_q, sum_abs_d;
    logic [CNTW+2:0]   hd_sum_q, hd_sum_d;

    logic              accept;
    logic              clear;
    logic              in_ready_c;

    // |a - b| taken through a W+1 bit signed difference; always fits in W bits.
    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0] d;
        logic signed [W:0] m;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        m = (d < 0) ? -d : d;
        return m[W-1:0];
    endfunction

    function automatic logic [HDW-1:0] popcnt(input logic [W-1:0] v);
        logic [HDW-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + HDW'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [W-1:0] max_of(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clear      = 1'b0;
        accept     = 1'b0;
        in_ready_c = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mon.start) begin
                    state_d = S_RUN;
                    clear   = 1'b1;
                end
            end
            S_RUN: begin
                in_ready_c = 1'b1;
                busy       = 1'b1;
                accept     = mon.in_valid;
                if (mon.in_valid && (samp_cnt_q == LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (mon.start) begin
                    state_d = S_RUN;
                    clear   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mon.in_ready = in_ready_c;

    // Stats only move on an accept, so pair data is never looked at while in_valid is low.
    always_comb begin
        logic [W-1:0] a;
        a          = abs_diff(mon.approx, mon.exact);
        samp_cnt_d = samp_cnt_q;
        err_cnt_d  = err_cnt_q;
        max_err_d  = max_err_q;
        sum_abs_d  = sum_abs_q;
        hd_sum_d   = hd_sum_q;
        if (clear) begin
            samp_cnt_d = '0;
            err_cnt_d  = '0;
            max_err_d  = '0;
            sum_abs_d  = '0;
            hd_sum_d   = '0;
        end else if (accept) begin
            samp_cnt_d = samp_cnt_q + 1'b1;
            err_cnt_d  = err_cnt_q + CNTW'(mon.approx != mon.exact);
            max_err_d  = max_of(max_err_q, a);
            sum_abs_d  = sum_abs_q + (CNTW + W)'(a);
            hd_sum_d   = hd_sum_q + (CNTW + 3)'(popcnt(mon.approx ^ mon.exact));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_cnt_q <= '0;
            err_cnt_q  <= '0;
            max_err_q  <= '0;
            sum_abs_q  <= '0;
            hd_sum_q   <= '0;
        end else begin
            samp_cnt_q <= samp_cnt_d;
            err_cnt_q  <= err_cnt_d;
            max_err_q  <= max_err_d;
            sum_abs_q  <= sum_abs_d;
            hd_sum_q   <= hd_sum_d;
        end
    end

    assign samp_cnt    = samp_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign max_err     = max_err_q;
    assign sum_abs_err = sum_abs_q;
    assign hd_sum      = hd_sum_q;

endmodule
